// File: rtl/if_id_queue_pkg.sv
// Shared types and helpers for the IF/ID decoupling queue.
// The optional zero-latency path is enabled with IFQ_BYPASS_EN (see if_id_queue).
package if_id_pkg;

    localparam int WORD_W = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [WORD_W-1:0] pc4;
        logic [WORD_W-1:0] instruction;
    } fetch_entry_t;

    // Circular increment for any DEPTH, power of two or not.
    function automatic int ptrWrap(int ptr, int depth);
        return (ptr >= depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/if_id_queue_if.sv
// Fetch/decode side signals of the IF/ID queue, grouped as one bus.
// master = fetch + decode environment, slave = the queue itself.
interface if_id_queue_if #(
    parameter int WORD_W = if_id_pkg::WORD_W
);
    logic              inValid;
    logic [WORD_W-1:0] inPc4;
    logic [WORD_W-1:0] inInstruction;
    logic              inReady;
    logic              flush;
    logic              outValid;
    logic [WORD_W-1:0] outPc4;
    logic [WORD_W-1:0] outInstruction;
    logic              outReady;

    modport master (
        output inValid, inPc4, inInstruction, flush, outReady,
        input  inReady, outValid, outPc4, outInstruction
    );

    modport slave (
        input  inValid, inPc4, inInstruction, flush, outReady,
        output inReady, outValid, outPc4, outInstruction
    );
endinterface

// File: rtl/if_id_queue_storage.sv
// Entry array for the IF/ID queue: synchronous write, asynchronous read,
// asynchronously cleared on resetN.
module ifq_storage
    import if_id_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int PTR_W = 1
) (
    input  logic             clock,
    input  logic             resetN,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  fetch_entry_t     wdata,
    input  logic [PTR_W-1:0] raddr,
    output fetch_entry_t     rdata
);

    fetch_entry_t mem [DEPTH];

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/if_id_queue.sv
// IF/ID decoupling queue: in-order {pc4, instruction} FIFO with flush and NOP bubble.
// Define IFQ_BYPASS_EN for a same-cycle path through an empty queue.
module if_id_queue
    import if_id_pkg::*;
#(
    parameter int DEPTH  = 2,
    // Entry layout is fixed by fetch_entry_t, so this must equal if_id_pkg::WORD_W.
    parameter int WORD_W = if_id_pkg::WORD_W
) (
    input  logic          clock,
    input  logic          resetN,
    if_id_queue_if.slave  bus
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0]  FULL_COUNT = CNT_W'(DEPTH);
    localparam logic [WORD_W-1:0] ZERO_WORD  = '0;

    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [CNT_W-1:0] count;
    logic             empty;
    logic             full;
    logic             bypass;
    logic             push;
    logic             pop;
    fetch_entry_t     wrEntry;
    fetch_entry_t     headEntry;

    assign empty = (count == '0);
    assign full  = (count == FULL_COUNT);

`ifdef IFQ_BYPASS_EN
    assign bypass = empty && bus.inValid && !bus.flush;
`else
    assign bypass = 1'b0;
`endif

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high in that cycle; flush cancels both sides. inReady depends only on
    // registered count, so it never combinationally follows outReady.
    assign push = bus.inValid && !full && !bus.flush && !(bypass && bus.outReady);
    assign pop  = !empty && bus.outReady && !bus.flush;

    assign bus.inReady = !full;

    always_comb begin
        bus.outValid       = 1'b0;
        bus.outPc4         = ZERO_WORD;
        bus.outInstruction = WORD_W'(NOP_INSTR);
        if (!empty) begin
            bus.outValid       = 1'b1;
            bus.outPc4         = headEntry.pc4;
            bus.outInstruction = headEntry.instruction;
        end else if (bypass) begin
            bus.outValid       = 1'b1;
            bus.outPc4         = bus.inPc4;
            bus.outInstruction = bus.inInstruction;
        end
    end

    assign wrEntry = '{pc4: bus.inPc4, instruction: bus.inInstruction};

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else if (bus.flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) wrPtr <= PTR_W'(ptrWrap(int'(wrPtr), DEPTH));
            if (pop)  rdPtr <= PTR_W'(ptrWrap(int'(rdPtr), DEPTH));
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    ifq_storage #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_storage (
        .clock  (clock),
        .resetN (resetN),
        .we     (push),
        .waddr  (wrPtr),
        .wdata  (wrEntry),
        .raddr  (rdPtr),
        .rdata  (headEntry)
    );

endmodule
